otter_mem_arbiter: RTL and testbench

//   Parametrised round-robin arbiter sharing one burst main memory among NUM_REQ cache-line

---
 rtl/otter_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mem_arbiter.sv
// Round-robin arbiter that serialises whole-line read/write bursts from several
// cache-line adapters onto one single-port burst memory, with a read time-out.
module otter_mem_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                        MEM_CLK,
    input  logic                        MEM_RST_N,
    input  logic [NUM_REQ-1:0]          REQ_RE,
    input  logic [NUM_REQ-1:0]          REQ_WE,
    input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]          REQ_GNT,
    output logic [NUM_REQ-1:0]          REQ_WACK,
    output logic [NUM_REQ-1:0]          REQ_RVALID,
    output logic [DATA_W-1:0]           REQ_RDATA,
    output logic [NUM_REQ-1:0]          REQ_DONE,
    output logic [NUM_REQ-1:0]          REQ_ERR,
    output logic                        M_RE,
    output logic                        M_WE,
    output logic [ADDR_W-1:0]           M_ADDR,
    output logic [DATA_W-1:0]           M_WDATA,
    input  logic [DATA_W-1:0]           M_RDATA,
    input  logic                        M_VALID
);

    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = $clog2(BURST_LEN * DATA_W / 8);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]     LAST_REQ  = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_BEAT,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [GW-1:0]       r_gidx, w_gidx_nxt;
    logic [GW-1:0]       r_rr, w_rr_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic [BW-1:0]       r_beat, w_beat_nxt;
    logic [TW-1:0]       r_tmo, w_tmo_nxt;
    logic                r_err, w_err_nxt;

    logic [NUM_REQ-1:0]  w_pending;
    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [GW-1:0]       w_pick, w_pick_hi;
    logic                w_any, w_any_hi;
    logic [ADDR_W-1:0]   w_pick_addr;
    logic [DATA_W-1:0]   w_gnt_wdata;

    assign w_pending = REQ_RE | REQ_WE;
    assign w_pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign REQ_GNT   = r_gnt;

    // Lowest pending index at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_any     = 1'b0;
        w_any_hi  = 1'b0;
        w_pick    = '0;
        w_pick_hi = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_any  = 1'b1;
                w_pick = GW'(i);
                if (GW'(i) >= r_rr) begin
                    w_any_hi  = 1'b1;
                    w_pick_hi = GW'(i);
                end
            end
        end
        if (w_any_hi) begin
            w_pick = w_pick_hi;
        end
    end

    always_comb begin
        w_pick_addr = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == w_pick) begin
                w_pick_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
            end
            if (GW'(i) == r_gidx) begin
                w_gnt_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // r_tmo counts cycles since the last memory activity; it trips one cycle early so
    // DONE lands exactly TIMEOUT cycles after that activity.
    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr;
        w_gnt_nxt   = r_gnt;
        w_base_nxt  = r_base;
        w_beat_nxt  = r_beat;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        REQ_WACK    = '0;
        REQ_RVALID  = '0;
        REQ_RDATA   = '0;
        REQ_DONE    = '0;
        REQ_ERR     = '0;
        M_RE        = 1'b0;
        M_WE        = 1'b0;
        M_ADDR      = '0;
        M_WDATA     = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gidx_nxt  = w_pick;
                    w_gnt_nxt   = w_pick_oh;
                    w_base_nxt  = w_pick_addr & LINE_MASK;
                    w_beat_nxt  = '0;
                    w_tmo_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = REQ_WE[w_pick] ? S_WR_BEAT : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                M_RE        = 1'b1;
                M_ADDR      = r_base;
                w_tmo_nxt   = TW'(1);
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (M_VALID) begin
                    REQ_RVALID = r_gnt;
                    REQ_RDATA  = M_RDATA;
                    w_tmo_nxt  = TW'(1);
                    w_beat_nxt = r_beat + BW'(1);
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (r_tmo >= TMO_LAST) begin
                    w_tmo_nxt   = r_tmo + TW'(1);
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_WR_BEAT: begin
                M_WE       = 1'b1;
                M_ADDR     = r_base + (ADDR_W'(r_beat) << BYTE_SH);
                M_WDATA    = w_gnt_wdata;
                REQ_WACK   = r_gnt;
                w_beat_nxt = r_beat + BW'(1);
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                REQ_DONE    = r_gnt;
                REQ_ERR     = r_err ? r_gnt : '0;
                w_rr_nxt    = (r_gidx == LAST_REQ) ? '0 : r_gidx + GW'(1);
                w_gnt_nxt   = '0;
                w_beat_nxt  = '0;
                w_tmo_nxt   = '0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_base  <= '0;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_rr    <= w_rr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_base  <= w_base_nxt;
            r_beat  <= w_beat_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed-plus-random bench for otter_mem_arbiter; expectations come from a
// transaction-level model of grant order, line addressing and read time-out.
module tb_otter_mem_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BURST_LEN  = 4;
    localparam int TIMEOUT    = 64;
    localparam int LINE_BYTES = BURST_LEN * DATA_W / 8;

    logic                      memClk;
    logic                      memRstN;
    logic [NUM_REQ-1:0]        reqRe;
    logic [NUM_REQ-1:0]        reqWe;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;
    logic [NUM_REQ*DATA_W-1:0] reqWdata;
    logic [NUM_REQ-1:0]        reqGnt;
    logic [NUM_REQ-1:0]        reqWack;
    logic [NUM_REQ-1:0]        reqRvalid;
    logic [DATA_W-1:0]         reqRdata;
    logic [NUM_REQ-1:0]        reqDone;
    logic [NUM_REQ-1:0]        reqErr;
    logic                      mRe;
    logic                      mWe;
    logic [ADDR_W-1:0]         mAddr;
    logic [DATA_W-1:0]         mWdata;
    logic [DATA_W-1:0]         mRdata;
    logic                      mValid;

    int total = 0;
    int bad = 0;
    int modelRr = 0;
    logic [ADDR_W-1:0] lineAddr [NUM_REQ];

    otter_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .MEM_CLK(memClk), .MEM_RST_N(memRstN),
        .REQ_RE(reqRe), .REQ_WE(reqWe), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
        .REQ_GNT(reqGnt), .REQ_WACK(reqWack), .REQ_RVALID(reqRvalid), .REQ_RDATA(reqRdata),
        .REQ_DONE(reqDone), .REQ_ERR(reqErr),
        .M_RE(mRe), .M_WE(mWe), .M_ADDR(mAddr), .M_WDATA(mWdata),
        .M_RDATA(mRdata), .M_VALID(mValid)
    );

    initial begin
        memClk = 1'b0;
        forever #5 memClk = ~memClk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory-side inputs just after the falling edge, then settle before sampling.
    task automatic applyStimulus(input logic mv, input logic [DATA_W-1:0] md);
        @(negedge memClk);
        mValid = mv;
        mRdata = md;
        #1;
    endtask

    task automatic setAddr(input int idx, input logic [ADDR_W-1:0] a);
        lineAddr[idx] = a;
        reqAddr[idx*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic int modelPick();
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (modelRr + k) % NUM_REQ;
            if (reqRe[i] || reqWe[i]) return i;
        end
        return -1;
    endfunction

    task automatic runRead(input int idx, input logic [ADDR_W-1:0] addr, input int delay,
                           input int answered, input bit keepReq);
        logic [NUM_REQ-1:0] oh;
        logic [ADDR_W-1:0]  base;
        logic [DATA_W-1:0]  data;
        int waits, reCount, silent;
        oh = '0;
        oh[idx] = 1'b1;
        base = addr - (addr % LINE_BYTES);
        waits = 0;
        do begin
            applyStimulus(1'b0, '0);
            waits++;
        end while (reqGnt == '0 && waits < 10);
        checkOutput("rdGntLatency", waits, 1);
        checkOutput("rdGnt", reqGnt, oh);
        checkOutput("rdIssue", mRe, 1'b1);
        checkOutput("rdIssueAddr", mAddr, base);
        reCount = 0;
        for (int d = 0; d < delay; d++) begin
            applyStimulus(1'b0, $urandom);
            reCount += int'(mRe);
        end
        for (int k = 0; k < answered; k++) begin
            if (k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    applyStimulus(1'b0, $urandom);
                    reCount += int'(mRe);
                end
            end
            data = $urandom;
            applyStimulus(1'b1, data);
            checkOutput("rdValid", reqRvalid, oh);
            checkOutput("rdData", reqRdata, data);
        end
        checkOutput("rdSingleIssue", reCount, 0);
        if (answered == BURST_LEN) begin
            applyStimulus(1'b1, $urandom);
            checkOutput("rdDone", reqDone, oh);
            checkOutput("rdNoErr", reqErr, '0);
            checkOutput("rdDoneNoValid", reqRvalid, '0);
        end else begin
            silent = 0;
            do begin
                applyStimulus(1'b0, '0);
                silent++;
            end while (reqDone == '0 && silent < TIMEOUT + 10);
            checkOutput("toCycles", silent, TIMEOUT);
            checkOutput("toDone", reqDone, oh);
            checkOutput("toErr", reqErr, oh);
        end
        modelRr = (idx + 1) % NUM_REQ;
        if (!keepReq) begin
            reqRe[idx] = 1'b0;
            reqWe[idx] = 1'b0;
        end
        applyStimulus(1'b1, $urandom);
        checkOutput("rdIdleGap", reqGnt, '0);
        checkOutput("rdStrayValid", reqRvalid, '0);
    endtask

    task automatic runWrite(input int idx, input logic [ADDR_W-1:0] addr, input int abortBeat);
        logic [DATA_W-1:0]  beat [BURST_LEN];
        logic [NUM_REQ-1:0] oh;
        logic [ADDR_W-1:0]  base;
        int waits;
        bit aborted;
        oh = '0;
        oh[idx] = 1'b1;
        base = addr - (addr % LINE_BYTES);
        for (int k = 0; k < BURST_LEN; k++) beat[k] = $urandom;
        reqWdata[idx*DATA_W +: DATA_W] = beat[0];
        aborted = 1'b0;
        waits = 0;
        do begin
            applyStimulus(1'b0, '0);
            waits++;
        end while (reqGnt == '0 && waits < 10);
        checkOutput("wrGntLatency", waits, 1);
        checkOutput("wrGnt", reqGnt, oh);
        for (int k = 0; k < BURST_LEN && !aborted; k++) begin
            if (k > 0) begin
                @(negedge memClk);
                reqWdata[idx*DATA_W +: DATA_W] = beat[k];
                mValid = 1'b0;
                #1;
            end
            checkOutput("wrStrobe", mWe, 1'b1);
            checkOutput("wrNoRead", mRe, 1'b0);
            checkOutput("wrAddr", mAddr, base + ADDR_W'(k * (DATA_W / 8)));
            checkOutput("wrData", mWdata, beat[k]);
            checkOutput("wrAck", reqWack, oh);
            if (k == abortBeat) begin
                memRstN = 1'b0;
                #1;
                checkOutput("rstWeDrop", mWe, 1'b0);
                checkOutput("rstGntDrop", reqGnt, '0);
                checkOutput("rstAckDrop", reqWack, '0);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            applyStimulus(1'b0, '0);
            checkOutput("wrDone", reqDone, oh);
            checkOutput("wrNoErr", reqErr, '0);
            checkOutput("wrStrobeEnd", mWe, 1'b0);
            modelRr = (idx + 1) % NUM_REQ;
            reqRe[idx] = 1'b0;
            reqWe[idx] = 1'b0;
            applyStimulus(1'b0, '0);
            checkOutput("wrIdleGap", reqGnt, '0);
        end
    endtask

    initial begin
        int g;
        memRstN  = 1'b0;
        reqRe    = '1;
        reqWe    = '0;
        reqAddr  = '0;
        reqWdata = '0;
        mValid   = 1'b0;
        mRdata   = '0;
        setAddr(0, 32'h0000_0104);
        setAddr(1, 32'h0000_0208);
        repeat (3) applyStimulus(1'b1, $urandom);
        checkOutput("rstGnt", reqGnt, '0);
        checkOutput("rstWack", reqWack, '0);
        checkOutput("rstRvalid", reqRvalid, '0);
        checkOutput("rstRdata", reqRdata, '0);
        checkOutput("rstDone", reqDone, '0);
        checkOutput("rstErr", reqErr, '0);
        checkOutput("rstMRe", mRe, 1'b0);
        checkOutput("rstMWe", mWe, 1'b0);
        checkOutput("rstMAddr", mAddr, '0);
        checkOutput("rstMWdata", mWdata, '0);
        memRstN = 1'b1;
        modelRr = 0;

        g = modelPick();
        runRead(g, lineAddr[g], 10, BURST_LEN, 1'b0);
        g = modelPick();
        runRead(g, lineAddr[g], $urandom_range(0, 6), BURST_LEN, 1'b0);

        // Both strobes on one requester: the write must win.
        setAddr(1, 32'h0000_0020);
        reqRe[1] = 1'b1;
        reqWe[1] = 1'b1;
        runWrite(modelPick(), lineAddr[1], -1);

        setAddr(0, $urandom);
        setAddr(1, $urandom);
        reqRe = '1;
        for (int n = 0; n < 4; n++) begin
            g = modelPick();
            if (g >= 0) runRead(g, lineAddr[g], $urandom_range(0, 6), BURST_LEN, n < 2);
        end

        setAddr(0, $urandom);
        reqRe[0] = 1'b1;
        runRead(modelPick(), lineAddr[0], 0, 0, 1'b0);
        setAddr(1, $urandom);
        reqRe[1] = 1'b1;
        runRead(modelPick(), lineAddr[1], 3, 2, 1'b0);
        setAddr(0, $urandom);
        reqRe[0] = 1'b1;
        runRead(modelPick(), lineAddr[0], TIMEOUT - 2, BURST_LEN, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(reqRe[i] || reqWe[i]) && $urandom_range(0, 1) == 1) begin
                    setAddr(i, $urandom);
                    case ($urandom_range(0, 2))
                        0: reqRe[i] = 1'b1;
                        1: reqWe[i] = 1'b1;
                        default: begin reqRe[i] = 1'b1; reqWe[i] = 1'b1; end
                    endcase
                end
            end
            if (modelPick() < 0) begin
                setAddr(0, $urandom);
                reqRe[0] = 1'b1;
            end
            g = modelPick();
            if (reqWe[g]) runWrite(g, lineAddr[g], -1);
            else runRead(g, lineAddr[g], $urandom_range(0, 8), BURST_LEN, 1'b0);
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            g = modelPick();
            if (g >= 0) begin
                if (reqWe[g]) runWrite(g, lineAddr[g], -1);
                else runRead(g, lineAddr[g], $urandom_range(0, 8), BURST_LEN, 1'b0);
            end
        end

        setAddr(1, $urandom);
        reqWe[1] = 1'b1;
        runWrite(modelPick(), lineAddr[1], 2);
        repeat (2) begin
            applyStimulus(1'b0, '0);
            checkOutput("abortNoDone", reqDone, '0);
            checkOutput("abortNoGnt", reqGnt, '0);
        end
        reqRe = '0;
        reqWe = '0;
        memRstN = 1'b1;
        modelRr = 0;
        setAddr(0, $urandom);
        setAddr(1, $urandom);
        reqRe = '1;
        g = modelPick();
        runRead(g, lineAddr[g], $urandom_range(0, 6), BURST_LEN, 1'b0);
        g = modelPick();
        runRead(g, lineAddr[g], $urandom_range(0, 6), BURST_LEN, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
